cipher_load_sequencer: RTL and testbench

- Top-level controller that sequences the serial input capture unit and the block-cipher round core.
- On a user request it pulses the capture unit's start and waits for its done.
- It then latches the 32-bit data and 64-bit key, loads the round core, and issues ROUNDS round enables.
- It returns the result over a valid/ready handshake.

---
 rtl/cipher_load_sequencer_pkg.sv | 18 +
 rtl/cipher_load_sequencer_round_counter.sv | 39 +++
 rtl/cipher_load_sequencer.sv | 160 ++++++++++++++++
 tb/tb_cipher_load_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_load_sequencer_pkg.sv
// Shared types and widths for the cipher load sequencer and its round counter.
package cipher_seq_pkg;

  localparam int DATA_W = 32;
  localparam int KEY_W  = 64;
  // Wide enough for any practical capture timeout.
  localparam int TMO_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CAPT,
    LOAD,
    RUN,
    OUT
  } seq_state_e;

endpackage

// File: rtl/cipher_load_sequencer_round_counter.sv
// Round index counter: cleared before a run, advanced on each round enable, flags the final round.
module seq_round_counter #(
  parameter int ROUNDS  = 32,
  parameter int ROUND_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  output logic [ROUND_W-1:0] count,
  output logic               last
);

  localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(ROUNDS - 1);

  logic [ROUND_W-1:0] count_q;
  logic [ROUND_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + ROUND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == LAST_IDX);

endmodule

// File: rtl/cipher_load_sequencer.sv
// Sequencer: capture start/done, load the round core, issue ROUNDS enables, return result via valid/ready.
// Optional capture timeout with sticky err is enabled by defining SEQ_TIMEOUT_EN.
module cipher_load_sequencer
  import cipher_seq_pkg::*;
#(
  parameter int ROUNDS  = 32,
  parameter int ROUND_W = 6,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  output logic               busy,
  output logic               it_start,
  input  logic               it_done,
  input  logic [DATA_W-1:0]  it_data,
  input  logic [KEY_W-1:0]   it_key,
  output logic               core_load,
  output logic [DATA_W-1:0]  core_data,
  output logic [KEY_W-1:0]   core_key,
  output logic               core_round_en,
  output logic [ROUND_W-1:0] core_round_idx,
  input  logic [DATA_W-1:0]  core_out,
  output logic [DATA_W-1:0]  res_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               err
);

  seq_state_e state_q, state_d;

  logic              busy_q, busy_d;
  logic              it_start_q, it_start_d;
  logic              core_load_q, core_load_d;
  logic              round_en_q, round_en_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] core_data_q, core_data_d;
  logic [KEY_W-1:0]  core_key_q, core_key_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              err_q, err_d;

  logic cnt_clear;
  logic cnt_en;
  logic cnt_last;

`ifdef SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  seq_round_counter #(
    .ROUNDS  (ROUNDS),
    .ROUND_W (ROUND_W)
  ) u_round_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (core_round_idx),
    .last   (cnt_last)
  );

  // The index is cleared in LOAD so it reads 0 on the first enabled cycle and
  // parks on ROUNDS-1 during the drain cycle.
  assign cnt_clear = (state_q == LOAD);
  assign cnt_en    = round_en_q && !cnt_last;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    core_data_d = core_data_q;
    core_key_d  = core_key_q;
    res_data_d  = res_data_q;
`ifdef SEQ_TIMEOUT_EN
    tmo_d       = '0;
`endif

    case (state_q)
      IDLE:  if (req) state_d = START;
      START: state_d = CAPT;
      CAPT: begin
        if (it_done) begin
          state_d     = LOAD;
          core_data_d = it_data;
          core_key_d  = it_key;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      LOAD:  state_d = RUN;
      RUN: begin
        // Enables have finished: this is the drain cycle where core_out is final.
        if (!round_en_q) begin
          state_d    = OUT;
          res_data_d = core_out;
        end
      end
      OUT:   if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    it_start_d  = (state_d == START);
    core_load_d = (state_d == LOAD);
    res_valid_d = (state_d == OUT);
    round_en_d  = (state_q == LOAD) || ((state_q == RUN) && round_en_q && !cnt_last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      it_start_q  <= 1'b0;
      core_load_q <= 1'b0;
      round_en_q  <= 1'b0;
      res_valid_q <= 1'b0;
      core_data_q <= '0;
      core_key_q  <= '0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      it_start_q  <= it_start_d;
      core_load_q <= core_load_d;
      round_en_q  <= round_en_d;
      res_valid_q <= res_valid_d;
      core_data_q <= core_data_d;
      core_key_q  <= core_key_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
`ifdef SEQ_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign it_start      = it_start_q;
  assign core_load     = core_load_q;
  assign core_round_en = round_en_q;
  assign res_valid     = res_valid_q;
  assign core_data     = core_data_q;
  assign core_key      = core_key_q;
  assign res_data      = res_data_q;
`ifdef SEQ_TIMEOUT_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_cipher_load_sequencer.sv
// Directed bench for cipher_load_sequencer: ROUNDS=32 instance plus a ROUNDS=1 instance.
module tb_cipher_load_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] it_data;
  logic [63:0] it_key;

  logic        req0, busy0, it_start0, it_done0, core_load0, round_en0;
  logic [31:0] core_data0, core_out0, res_data0;
  logic [63:0] core_key0;
  logic [5:0]  idx0;
  logic        res_valid0, res_ready0, err0;

  logic        req1, busy1, it_start1, it_done1, core_load1, round_en1;
  logic [31:0] core_data1, core_out1, res_data1;
  logic [63:0] core_key1;
  logic [5:0]  idx1;
  logic        res_valid1, res_ready1, err1;

  cipher_load_sequencer #(.ROUNDS(32), .ROUND_W(6), .TIMEOUT(16)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .busy(busy0), .it_start(it_start0),
    .it_done(it_done0), .it_data(it_data), .it_key(it_key), .core_load(core_load0),
    .core_data(core_data0), .core_key(core_key0), .core_round_en(round_en0),
    .core_round_idx(idx0), .core_out(core_out0), .res_data(res_data0),
    .res_valid(res_valid0), .res_ready(res_ready0), .err(err0)
  );

  cipher_load_sequencer #(.ROUNDS(1), .ROUND_W(6), .TIMEOUT(16)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .busy(busy1), .it_start(it_start1),
    .it_done(it_done1), .it_data(it_data), .it_key(it_key), .core_load(core_load1),
    .core_data(core_data1), .core_key(core_key1), .core_round_en(round_en1),
    .core_round_idx(idx1), .core_out(core_out1), .res_data(res_data1),
    .res_valid(res_valid1), .res_ready(res_ready1), .err(err1)
  );

  // Core model: load the plaintext, then add (idx+1) on each round enable.
  always @(posedge clk) begin
    if (core_load0) core_out0 <= core_data0;
    else if (round_en0) core_out0 <= core_out0 + 32'(idx0) + 32'd1;
    if (core_load1) core_out1 <= core_data1;
    else if (round_en1) core_out1 <= core_out1 + 32'(idx1) + 32'd1;
  end

  int cyc = 0;
  int last_done = -1000;
  int last_gap = 0;
  int min_gap = 1000000;
  int starts0 = 0;
  int loads0 = 0;
  int rounds0 = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (it_done0) last_done <= cyc;
    if (it_start0) begin
      last_gap <= cyc - last_done;
      if (cyc - last_done < min_gap) min_gap <= cyc - last_done;
      starts0 <= starts0 + 1;
    end
    if (core_load0) loads0 <= loads0 + 1;
    if (round_en0) rounds0 <= rounds0 + 1;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_start0(input string tag);
    int k = 0;
    while (!it_start0 && k < 20) begin step(); k++; end
    chk(tag, it_start0, 1);
  endtask

  task automatic wait_valid0(input string tag);
    int k = 0;
    while (!res_valid0 && k < 80) begin step(); k++; end
    chk(tag, res_valid0, 1);
  endtask

  task automatic capture0(input logic [31:0] d, input logic [63:0] k);
    it_data = d;
    it_key = k;
    it_done0 = 1'b1;
    step();
    it_done0 = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_it_start"}, it_start0, 0);
    chk({tag, "_core_load"}, core_load0, 0);
    chk({tag, "_core_data"}, core_data0, 0);
    chk({tag, "_core_key"}, core_key0, 0);
    chk({tag, "_round_en"}, round_en0, 0);
    chk({tag, "_idx"}, idx0, 0);
    chk({tag, "_res_data"}, res_data0, 0);
    chk({tag, "_res_valid"}, res_valid0, 0);
    chk({tag, "_err"}, err0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    req0 = 0; it_done0 = 0; res_ready0 = 1;
    req1 = 0; it_done1 = 0; res_ready1 = 1;
    it_data = '0; it_key = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    chk_all_zero("reset");
    chk("reset_busy1", busy1, 0);
    reset = 1'b0;
    step();

    // Basic run, ROUNDS=32, ready tied high
    req0 = 1;
    step();
    chk("basic_start", it_start0, 1);
    chk("basic_busy", busy0, 1);
    req0 = 0;
    step();
    chk("basic_start_once", it_start0, 0);
    step();
    step();
    capture0(32'hDEADBEEF, 64'h0123456789ABCDEF);
    chk("basic_load", core_load0, 1);
    chk("basic_core_data", core_data0, 32'hDEADBEEF);
    chk("basic_core_key", core_key0, 64'h0123456789ABCDEF);
    for (int i = 0; i < 32; i++) begin
      step();
      if (i == 0) chk("basic_load_once", core_load0, 0);
      chk($sformatf("basic_round_en_%0d", i), round_en0, 1);
      chk($sformatf("basic_idx_%0d", i), idx0, i);
    end
    step();
    chk("basic_drain_en", round_en0, 0);
    chk("basic_drain_valid", res_valid0, 0);
    step();
    chk("basic_valid_d35", res_valid0, 1);
    chk("basic_res_data", res_data0, 32'hDEADC0FF);
    step();
    chk("basic_valid_drop", res_valid0, 0);
    chk("basic_idle", busy0, 0);

    // Backpressure: ready low for 10 cycles after valid rises
    res_ready0 = 0;
    req0 = 1;
    wait_start0("bp_start");
    req0 = 0;
    step();
    capture0(32'h00000000, 64'hFFFF0000FFFF0000);
    wait_valid0("bp_valid_rise");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_hold_valid_%0d", i), res_valid0, 1);
      chk($sformatf("bp_hold_data_%0d", i), res_data0, 32'h00000210);
      step();
    end
    chk("bp_valid_before_hs", res_valid0, 1);
    res_ready0 = 1;
    step();
    chk("bp_valid_after_hs", res_valid0, 0);
    chk("bp_idle", busy0, 0);

    // Request held high across two back-to-back operations
    base = starts0;
    req0 = 1;
    wait_start0("rq_start1");
    step();
    capture0(32'h11111111, 64'h1);
    wait_valid0("rq_valid1");
    chk("rq_data1", res_data0, 32'h11111321);
    step();
    wait_start0("rq_start2");
    step();
    chk("rq_gap", last_gap, 37);
    capture0(32'h22222222, 64'h2);
    wait_valid0("rq_valid2");
    chk("rq_data2", res_data0, 32'h22222432);
    step();
    req0 = 0;
    repeat (5) step();
    chk("rq_start_count", starts0 - base, 2);
    chk("rq_min_gap_ok", (min_gap >= 3), 1);

    // Reset in the middle of RUN
    req0 = 1;
    wait_start0("rst_start");
    req0 = 0;
    step();
    capture0(32'h12345678, 64'hA5A5A5A5A5A5A5A5);
    k = 0;
    while (!(round_en0 && idx0 == 6'd5) && k < 20) begin step(); k++; end
    chk("rst_reach_round5", idx0, 5);
    reset = 1;
    step();
    chk_all_zero("rst_mid");
    reset = 0;
    step();
    chk("rst_still_idle", busy0, 0);
    base = rounds0;
    req0 = 1;
    wait_start0("rst_restart");
    req0 = 0;
    step();
    capture0(32'h12345678, 64'hA5A5A5A5A5A5A5A5);
    chk("rst_core_key", core_key0, 64'hA5A5A5A5A5A5A5A5);
    wait_valid0("rst_valid");
    chk("rst_res_data", res_data0, 32'h12345888);
    chk("rst_round_count", rounds0 - base, 32);
    step();
    chk("rst_idle", busy0, 0);

    // ROUNDS=1 instance
    req1 = 1;
    step();
    chk("r1_start", it_start1, 1);
    req1 = 0;
    step();
    it_data = 32'hCAFEF00D;
    it_key = 64'h0;
    it_done1 = 1;
    step();
    it_done1 = 0;
    chk("r1_load", core_load1, 1);
    chk("r1_core_data", core_data1, 32'hCAFEF00D);
    step();
    chk("r1_round_en", round_en1, 1);
    chk("r1_idx", idx1, 0);
    step();
    chk("r1_drain_en", round_en1, 0);
    chk("r1_drain_valid", res_valid1, 0);
    step();
    chk("r1_valid_d4", res_valid1, 1);
    chk("r1_res_data", res_data1, 32'hCAFEF00E);
    step();
    chk("r1_valid_drop", res_valid1, 0);

`ifdef SEQ_TIMEOUT_EN
    // Capture timeout: it_done never arrives
    base = loads0;
    req0 = 1;
    wait_start0("tmo_start");
    req0 = 0;
    step();
    repeat (15) step();
    chk("tmo_err_before", err0, 0);
    step();
    chk("tmo_err_set", err0, 1);
    chk("tmo_idle", busy0, 0);
    chk("tmo_no_load", loads0 - base, 0);
    repeat (5) step();
    chk("tmo_err_sticky", err0, 1);
    reset = 1;
    step();
    reset = 0;
    chk("tmo_err_cleared", err0, 0);
`else
    chk("err_tied_low", err0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
